// File: rtl/seq_1011_tx_pkg.sv
// ----------------------------------------------------------------------------
// seq_pkg
//
// Shared definitions for the 1011 serial link. The transmitter uses them, and
// so does the matching sequence detector.
//   SYNC_WORD / SYNC_LEN : frame sync pattern and its length in bits
//   state_t              : transmitter FSM state encoding (one-hot)
//   cnt_width()          : bit counter width, sized to hold
//                          max(SYNC_LEN, DATA_W, GAP_LEN) - 1
// ----------------------------------------------------------------------------
package seq_pkg;

    localparam logic [3:0] SYNC_WORD = 4'b1011;
    localparam int         SYNC_LEN  = 4;

    // One-hot encoding. Any other bit pattern is illegal, and the FSM
    // recovers from it by returning to IDLE.
    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        SYNC = 4'b0010,
        DATA = 4'b0100,
        GAP  = 4'b1000
    } state_t;

    // Width of a counter that must reach the last index of the longest phase.
    function automatic int cnt_width(input int data_w, input int gap_len);
        int longest;
        longest = SYNC_LEN;
        if (data_w > longest) longest = data_w;
        if (gap_len > longest) longest = gap_len;
        // longest is at least 4, so the result is at least 2 bits.
        return $clog2(longest);
    endfunction

endpackage : seq_pkg

// File: rtl/seq_1011_tx_if.sv
// ----------------------------------------------------------------------------
// seq_1011_tx_if
//
// Groups the upstream valid/ready handshake and the serial-side outputs of the
// 1011 frame transmitter.
//   in_data  [DATA_W] : payload word, sampled only at handshake
//   in_valid          : upstream has a word
//   in_ready          : transmitter can accept (IDLE only)
//   dout              : serial bit stream
//   sof               : first sync bit of a frame
//   busy              : transmitter is not IDLE
// modport master : upstream data source / observer
// modport slave  : the transmitter
// ----------------------------------------------------------------------------
interface seq_1011_tx_if #(
    parameter int DATA_W = 8
);

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              dout;
    logic              sof;
    logic              busy;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  dout,
        input  sof,
        input  busy
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output dout,
        output sof,
        output busy
    );

endinterface : seq_1011_tx_if

// File: rtl/seq_1011_tx_piso_shift.sv
// ----------------------------------------------------------------------------
// piso_shift
//
// Parallel-in / serial-out register. It presents its MSB, shifts left and
// fills with zeros.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, clears the register
//   i_load   : capture i_data (takes priority over i_shift)
//   i_shift  : shift left by one, zero fill
//   i_data   : parallel word
//   o_msb    : current MSB (next serial bit)
// ----------------------------------------------------------------------------
module piso_shift #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_shift,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_msb
);

    logic [DATA_W-1:0] r_shreg;

    // NOTE: the shift register is a plain register, not a memory, so it gets
    // reset. A frame abandoned by reset then leaves no stale payload behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg <= '0;
        end else if (i_load) begin
            r_shreg <= i_data;
        end else if (i_shift) begin
            r_shreg <= r_shreg << 1;
        end
    end

    assign o_msb = r_shreg[DATA_W-1];

endmodule : piso_shift

// File: rtl/seq_1011_tx.sv
// ----------------------------------------------------------------------------
// seq_1011_tx
//
// Serial frame transmitter for the 1011 link. Each accepted word goes out as
// the sync word 1011, then DATA_W payload bits MSB-first, then GAP_LEN zero
// guard bits. One IDLE cycle always separates consecutive frames.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset; abandons any frame in flight
//   bus  : seq_1011_tx_if.slave. The handshake inputs are in_data and
//          in_valid. The outputs are in_ready, dout, sof and busy.
// All outputs are Moore-decoded from state, counter and shift register. No
// output depends combinationally on in_valid or in_data.
// ----------------------------------------------------------------------------
module seq_1011_tx
    import seq_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int GAP_LEN = 2
) (
    input  logic         clk,
    input  logic         rst,
    seq_1011_tx_if.slave bus
);

    localparam int CNT_W = cnt_width(DATA_W, GAP_LEN);

    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LEN - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    logic       w_idle;
    logic       w_load;
    logic       w_shift;
    logic       w_msb;
    logic       w_dout;
    logic [1:0] w_sync_idx;

    assign w_idle = (r_state == IDLE);

    // in_ready equals w_idle, so this is the handshake. in_valid is ignored
    // in every other state.
    assign w_load  = w_idle && bus.in_valid;
    assign w_shift = (r_state == DATA);

    piso_shift #(
        .DATA_W (DATA_W)
    ) u_piso (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  (bus.in_data),
        .o_msb   (w_msb)
    );

    // ------------------------------------------------------------------------
    // FSM and bit counter. The counter restarts at zero at every phase
    // boundary and is compared against that phase's last index.
    // ------------------------------------------------------------------------
    // NOTE: state and counter use non-blocking assignments, so every register
    // in this block updates from the values before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (bus.in_valid) begin
                        r_state <= SYNC;
                    end
                end
                SYNC: begin
                    if (r_cnt == SYNC_LAST) begin
                        r_state <= DATA;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_cnt == DATA_LAST) begin
                        r_state <= GAP;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------------
    // The sync word goes out MSB first: cnt 0..3 selects bits 3..0.
    assign w_sync_idx = 2'd3 - r_cnt[1:0];

    // NOTE: w_dout gets a default before the case, so no path can leave it
    // unassigned and infer a latch.
    always_comb begin
        w_dout = 1'b0;
        case (r_state)
            SYNC:    w_dout = SYNC_WORD[w_sync_idx];
            DATA:    w_dout = w_msb;
            default: w_dout = 1'b0;
        endcase
    end

    assign bus.dout     = w_dout;
    assign bus.sof      = (r_state == SYNC) && (r_cnt == '0);
    assign bus.busy     = !w_idle;
    assign bus.in_ready = w_idle;

endmodule : seq_1011_tx

// File: tb/tb_seq_1011_tx.sv
// ----------------------------------------------------------------------------
// tb_seq_1011_tx
//
// Directed bench for seq_1011_tx with default parameters (DATA_W=8,
// GAP_LEN=2). Outputs are sampled 1 time unit after the rising edge. A small
// 1011 matcher models a loopback detector on dout.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_seq_1011_tx;

    logic clk = 1'b0;
    logic rst;

    seq_1011_tx_if #(.DATA_W(8)) bus ();

    seq_1011_tx #(
        .DATA_W  (8),
        .GAP_LEN (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Loopback detector model. It watches dout once per cycle and counts
    // every time the last four bits read 1011 (overlapping allowed).
    logic [3:0] det_hist     = 4'b0000;
    int         det_cnt      = 0;
    int         det_last_cyc = -1;

    always @(negedge clk) begin
        det_hist <= {det_hist[2:0], bus.dout};
        if ({det_hist[2:0], bus.dout} == 4'b1011) begin
            det_cnt      <= det_cnt + 1;
            det_last_cyc <= cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word and wait (bounded) for the handshake edge. k is the
    // cycle index right after that edge, where the first sync bit appears.
    task automatic send_frame(input logic [7:0] d, output int k);
        int waited;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        waited = 0;
        while (!bus.in_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!bus.in_ready) check("handshake_timeout", 32'(waited), 32'd0);
        tick();
        k = cyc;
        bus.in_valid = 1'b0;
    endtask

    // Sample 14 frame cycles starting at the current cycle. With agitate set,
    // in_valid toggles and in_data changes every cycle.
    task automatic collect(input bit agitate, output logic [13:0] bits,
                           output int sof_cnt, output logic first_sof,
                           output int busy_cnt, output int rdy_cnt);
        sof_cnt  = 0;
        busy_cnt = 0;
        rdy_cnt  = 0;
        first_sof = bus.sof;
        for (int i = 0; i < 14; i++) begin
            bits[13-i] = bus.dout;
            if (bus.sof)      sof_cnt++;
            if (bus.busy)     busy_cnt++;
            if (bus.in_ready) rdy_cnt++;
            if (agitate) begin
                bus.in_valid = ~bus.in_valid;
                bus.in_data  = (i % 2 == 0) ? 8'hFF : 8'h00;
            end
            tick();
        end
    endtask

    logic [13:0] bits;
    int          sof_cnt, busy_cnt, rdy_cnt, k, det0, ones;
    logic        first_sof;
    logic        d_arr [0:28];
    logic        s_arr [0:28];
    logic        r_arr [0:28];
    logic [13:0] s1, s2;
    int          sof_pos [$];

    initial begin
        // ---------------- reset with in_valid high ----------------
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        tick();
        tick();
        check("rst_dout",     32'(bus.dout),     32'd0);
        check("rst_sof",      32'(bus.sof),      32'd0);
        check("rst_busy",     32'(bus.busy),     32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        check("rst_no_handshake", 32'(bus.busy), 32'd0);

        // ---------------- single frame A5 + loopback ----------------
        det0 = det_cnt;
        send_frame(8'hA5, k);
        collect(1'b0, bits, sof_cnt, first_sof, busy_cnt, rdy_cnt);
        check("a5_stream",    32'(bits),     32'(14'b10111010010100));
        check("a5_sof_first", 32'(first_sof), 32'd1);
        check("a5_sof_count", 32'(sof_cnt),  32'd1);
        check("a5_busy_len",  32'(busy_cnt), 32'd14);
        check("a5_ready_low", 32'(rdy_cnt),  32'd0);
        check("a5_ready_end", 32'(bus.in_ready), 32'd1);
        check("a5_busy_end",  32'(bus.busy), 32'd0);
        tick();
        check("a5_det_count", 32'(det_cnt - det0), 32'd1);
        check("a5_det_cycle", 32'(det_last_cyc - k), 32'd3);

        // ---------------- back-to-back FF then 00 ----------------
        send_frame(8'hFF, k);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h00;
        for (int i = 0; i < 29; i++) begin
            d_arr[i] = bus.dout;
            s_arr[i] = bus.sof;
            r_arr[i] = bus.in_ready;
            if (i == 15) bus.in_valid = 1'b0;
            tick();
        end
        for (int i = 0; i < 14; i++) begin
            s1[13-i] = d_arr[i];
            s2[13-i] = d_arr[15+i];
        end
        sof_pos.delete();
        for (int i = 0; i < 29; i++) if (s_arr[i]) sof_pos.push_back(i);
        check("b2b_stream_ff", 32'(s1), 32'(14'b10111111111100));
        check("b2b_stream_00", 32'(s2), 32'(14'b10110000000000));
        check("b2b_sof_count", 32'(sof_pos.size()), 32'd2);
        if (sof_pos.size() == 2)
            check("b2b_sof_period", 32'(sof_pos[1] - sof_pos[0]), 32'd15);
        check("b2b_idle_dout",  32'(d_arr[14]), 32'd0);
        check("b2b_idle_ready", 32'(r_arr[14]), 32'd1);
        check("b2b_busy_end",   32'(bus.busy),  32'd0);

        // ---------------- input stability 5A ----------------
        send_frame(8'h5A, k);
        collect(1'b1, bits, sof_cnt, first_sof, busy_cnt, rdy_cnt);
        bus.in_valid = 1'b0;
        check("stab_stream",    32'(bits),    32'(14'b10110101101000));
        check("stab_sof_count", 32'(sof_cnt), 32'd1);
        check("stab_idle",      32'(bus.busy), 32'd0);
        tick();
        check("stab_no_extra",  32'(bus.busy), 32'd0);

        // ---------------- reset mid-frame ----------------
        send_frame(8'hA5, k);
        for (int i = 0; i < 6; i++) tick();   // now on the 3rd payload bit
        rst = 1'b1;
        tick();
        check("mrst_dout",  32'(bus.dout),     32'd0);
        check("mrst_busy",  32'(bus.busy),     32'd0);
        check("mrst_ready", 32'(bus.in_ready), 32'd1);
        rst  = 1'b0;
        ones = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.dout) ones++;
        end
        check("mrst_quiet", 32'(ones), 32'd0);
        send_frame(8'h3C, k);
        collect(1'b0, bits, sof_cnt, first_sof, busy_cnt, rdy_cnt);
        check("mrst_3c_stream", 32'(bits), 32'(14'b10110011110000));
        check("mrst_3c_sof",    32'(first_sof), 32'd1);

        // ---------------- loopback B0: embedded 1011 ----------------
        det0 = det_cnt;
        send_frame(8'hB0, k);
        collect(1'b0, bits, sof_cnt, first_sof, busy_cnt, rdy_cnt);
        tick();
        check("b0_stream",    32'(bits), 32'(14'b10111011000000));
        check("b0_det_count", 32'(det_cnt - det0), 32'd2);
        check("b0_det_last",  32'(det_last_cyc - k), 32'd7);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_seq_1011_tx
